// File: rtl/i2c_config_sequencer_if.sv
// Signal bundle between the init-table sequencer, its table ROM and the I2C byte writer.
// master = sequencer side, slave = table ROM / writer / controller side.
interface i2c_config_sequencer_if #(
  parameter int unsigned TBL_AW = 8
);
  logic              START;
  logic              BUSY;
  logic              DONE;
  logic              ERR;
  logic [TBL_AW-1:0] ERR_IDX;
  logic [TBL_AW-1:0] TBL_ADDR;
  logic [31:0]       TBL_DATA;
  logic              W_GO;
  logic [7:0]        W_SLAVE_ADDRESS;
  logic [7:0]        W_BYTE_NUM;
  logic [15:0]       W_REG_DATA;
  logic              W_END_OK;
  logic              W_ACK_ERR;

  modport master (
    input  START, TBL_DATA, W_END_OK, W_ACK_ERR,
    output BUSY, DONE, ERR, ERR_IDX, TBL_ADDR,
           W_GO, W_SLAVE_ADDRESS, W_BYTE_NUM, W_REG_DATA
  );

  modport slave (
    output START, TBL_DATA, W_END_OK, W_ACK_ERR,
    input  BUSY, DONE, ERR, ERR_IDX, TBL_ADDR,
           W_GO, W_SLAVE_ADDRESS, W_BYTE_NUM, W_REG_DATA
  );
endinterface

// File: rtl/i2c_config_sequencer.sv
// Walks a register-init table and drives one I2C_WRITE_WDATA transfer per entry via GO/END_OK.
// Optional macro I2C_SEQ_RETRY_EN: retry a NACKed entry up to MAX_RETRY times before flagging ERR.
module i2c_config_sequencer #(
  parameter int unsigned TBL_AW     = 8,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned DELAY_UNIT = 1000,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic                  PT_CK,
  input  logic                  RESET,
  i2c_config_sequencer_if.master bus
);

  localparam logic [3:0] S_PARK    = 4'd0;
  localparam logic [3:0] S_IDLE    = 4'd1;
  localparam logic [3:0] S_FETCH   = 4'd2;
  localparam logic [3:0] S_DECODE  = 4'd3;
  localparam logic [3:0] S_LAUNCH  = 4'd4;
  localparam logic [3:0] S_WAIT_LO = 4'd5;
  localparam logic [3:0] S_WAIT_HI = 4'd6;
  localparam logic [3:0] S_CHECK   = 4'd7;
  localparam logic [3:0] S_NEXT    = 4'd8;
  localparam logic [3:0] S_DELAY   = 4'd9;
  localparam logic [3:0] S_FIN     = 4'd10;
  localparam logic [3:0] S_ERR     = 4'd11;

`ifdef I2C_SEQ_RETRY_EN
  localparam logic RETRY_EN = 1'b1;
`else
  localparam logic RETRY_EN = 1'b0;
`endif

  localparam int unsigned RW           = $clog2(MAX_RETRY + 2);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
  localparam logic [31:0] UNIT_LAST    = 32'(DELAY_UNIT - 1);

  localparam logic [7:0] SLV_END   = 8'hFF;
  localparam logic [7:0] SLV_DELAY = 8'hFE;

  logic [3:0]        state_q, state_d;
  logic [TBL_AW-1:0] idx_q, idx_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [15:0]       units_q, units_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic              w_go_q, w_go_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [TBL_AW-1:0] err_idx_q, err_idx_d;
  logic [7:0]        slave_q, slave_d;
  logic [7:0]        byte_q, byte_d;
  logic [15:0]       reg_q, reg_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    units_d   = units_q;
    retry_d   = retry_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    slave_d   = slave_q;
    byte_d    = byte_q;
    reg_d     = reg_q;

    case (state_q)
      // Writer must see GO high for two cycles to reach its parked state.
      S_PARK: begin
        if (w_go_q) begin
          if (cnt_q == 32'd1) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end

      S_IDLE: begin
        if (bus.START) begin
          state_d = S_FETCH;
          idx_d   = '0;
          retry_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end

      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        if (bus.TBL_DATA[31:24] == SLV_END) begin
          state_d = S_FIN;
        end else if (bus.TBL_DATA[31:24] == SLV_DELAY) begin
          if (bus.TBL_DATA[15:0] == '0) begin
            state_d = S_NEXT;
          end else begin
            units_d = bus.TBL_DATA[15:0];
            cnt_d   = '0;
            state_d = S_DELAY;
          end
        end else begin
          slave_d = bus.TBL_DATA[31:24];
          byte_d  = bus.TBL_DATA[23:16];
          reg_d   = bus.TBL_DATA[15:0];
          state_d = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT_LO;
      end

      S_WAIT_LO: begin
        if (!bus.W_END_OK) begin
          cnt_d   = '0;
          state_d = S_WAIT_HI;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_WAIT_HI: begin
        if (bus.W_END_OK) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_CHECK: begin
        if (!bus.W_ACK_ERR) begin
          state_d = S_NEXT;
        end else if (RETRY_EN && (32'(retry_q) < MAX_RETRY)) begin
          retry_d = retry_q + RW'(1);
          state_d = S_LAUNCH;
        end else begin
          state_d = S_ERR;
        end
      end

      // Running off the end of the table without a terminator is a clean finish.
      S_NEXT: begin
        retry_d = '0;
        if (idx_q == '1) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + TBL_AW'(1);
          state_d = S_FETCH;
        end
      end

      // units_q counts remaining DELAY_UNIT blocks; cnt_q counts within a block.
      S_DELAY: begin
        if (cnt_q == UNIT_LAST) begin
          cnt_d   = '0;
          units_d = units_q - 16'd1;
          if (units_q == 16'd1) state_d = S_NEXT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      S_ERR: begin
        err_d     = 1'b1;
        err_idx_d = idx_q;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end

      default: state_d = S_PARK;
    endcase

    w_go_d = (state_d != S_LAUNCH);
  end

  always_ff @(posedge PT_CK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_PARK;
      idx_q     <= '0;
      cnt_q     <= '0;
      units_q   <= '0;
      retry_q   <= '0;
      w_go_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      slave_q   <= '0;
      byte_q    <= '0;
      reg_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      units_q   <= units_d;
      retry_q   <= retry_d;
      w_go_q    <= w_go_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      slave_q   <= slave_d;
      byte_q    <= byte_d;
      reg_q     <= reg_d;
    end
  end

  assign bus.BUSY            = busy_q;
  assign bus.DONE            = done_q;
  assign bus.ERR             = err_q;
  assign bus.ERR_IDX         = err_idx_q;
  assign bus.TBL_ADDR        = idx_q;
  assign bus.W_GO            = w_go_q;
  assign bus.W_SLAVE_ADDRESS = slave_q;
  assign bus.W_BYTE_NUM      = byte_q;
  assign bus.W_REG_DATA      = reg_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer: table ROM + byte-writer model, table-walk reference model, directed and random runs.
`timescale 1ns/1ps
module tb_i2c_config_sequencer;
  localparam int unsigned AW    = 4;
  localparam int unsigned N_ENT = 1 << AW;
  localparam int unsigned TO    = 64;
  localparam int unsigned DU    = 10;
  localparam int unsigned MR    = 3;
`ifdef I2C_SEQ_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_config_sequencer_if #(.TBL_AW(AW)) bus ();

  i2c_config_sequencer #(
    .TBL_AW(AW), .TIMEOUT(TO), .DELAY_UNIT(DU), .MAX_RETRY(MR)
  ) dut (
    .PT_CK(clk),
    .RESET(rst),
    .bus  (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] tbl [N_ENT];
  int          nack_plan [256];
  int          nack_left [256];
  int          len_min = 1;
  int          len_max = 12;
  bit          hang_lo = 1'b0;
  bit          hang_hi = 1'b0;
  logic [31:0] obs_q [$];
  logic [31:0] exp_q [$];
  int          dwell [N_ENT];
  int          cyc = 0;
  int          launch_cyc = 0;

  // synchronous table ROM, one cycle latency
  always @(posedge clk) bus.TBL_DATA <= tbl[bus.TBL_ADDR];

  // writer model: parks while GO high, a one-cycle GO low starts a transfer
  bit       w_armed;
  int       w_phase, w_cnt, w_len;
  logic [7:0] w_slave;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.W_END_OK  <= 1'b1;
      bus.W_ACK_ERR <= 1'b0;
      w_armed       <= 1'b0;
      w_phase       <= 0;
      w_cnt         <= 0;
      w_len         <= 1;
      w_slave       <= 8'h00;
    end else begin
      case (w_phase)
        0: begin
          if (bus.W_GO) w_armed <= 1'b1;
          else if (w_armed && !hang_lo) begin
            w_phase <= 1;
            w_cnt   <= 0;
            w_slave <= bus.W_SLAVE_ADDRESS;
            w_len   <= $urandom_range(len_max, len_min);
          end
        end
        1: begin
          if (w_cnt == 1) begin
            bus.W_END_OK <= 1'b0;
            w_phase      <= 2;
            w_cnt        <= 0;
          end else w_cnt <= w_cnt + 1;
        end
        default: begin
          if (!hang_hi && w_cnt >= w_len) begin
            bus.W_END_OK <= 1'b1;
            w_phase      <= 0;
            if (nack_left[w_slave] > 0) begin
              bus.W_ACK_ERR <= 1'b1;
              nack_left[w_slave] = nack_left[w_slave] - 1;
            end else bus.W_ACK_ERR <= 1'b0;
          end else w_cnt <= w_cnt + 1;
        end
      endcase
    end
  end

  // launch/dwell monitor plus the DONE/ERR exclusivity check, sampled on the falling edge
  bit m_armed = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (rst) m_armed = 1'b0;
    else begin
      if (bus.W_GO) m_armed = 1'b1;
      else if (m_armed) begin
        obs_q.push_back({bus.W_SLAVE_ADDRESS, bus.W_BYTE_NUM, bus.W_REG_DATA});
        launch_cyc = cyc;
      end
      if (bus.BUSY) dwell[bus.TBL_ADDR]++;
      n_assert++;
      assert (!(bus.DONE && bus.ERR)) else begin
        n_fail++;
        $error("FAIL done_err_excl: observed DONE=%0b ERR=%0b expected not both 1", bus.DONE, bus.ERR);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < N_ENT; i++) tbl[i] = 32'hFF00_0000;
    for (int s = 0; s < 256; s++) nack_plan[s] = 0;
  endtask

  // Reference: walk the table by the sequencing rules, listing every launch and the final outcome.
  task automatic model(output bit exp_err, output int exp_idx);
    logic [31:0] e;
    exp_q.delete();
    exp_err = 1'b0;
    exp_idx = 0;
    for (int i = 0; i < N_ENT; i++) begin
      e = tbl[i];
      if (e[31:24] == 8'hFF) return;
      if (e[31:24] == 8'hFE) continue;
      for (int a = 0; a <= int'(MR) + 1; a++) begin
        exp_q.push_back(e);
        if (a >= nack_plan[e[31:24]]) break;
        if (!RETRY || a >= int'(MR)) begin
          exp_err = 1'b1;
          exp_idx = i;
          return;
        end
      end
    end
  endtask

  task automatic run_seq(input string tag, input bit restart_mid);
    bit exp_err;
    int exp_idx;
    bit finished;
    model(exp_err, exp_idx);
    for (int s = 0; s < 256; s++) nack_left[s] = nack_plan[s];
    for (int i = 0; i < N_ENT; i++) dwell[i] = 0;
    obs_q.delete();
    pulse_start();
    check($sformatf("%s.busy", tag), 64'(bus.BUSY), 64'd1);
    finished = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      tick();
      if (restart_mid && c == 7) pulse_start();
      if (bus.DONE || bus.ERR) begin
        finished = 1'b1;
        break;
      end
    end
    check($sformatf("%s.finished", tag), 64'(finished), 64'd1);
    repeat (6) tick();
    check($sformatf("%s.n_launch", tag), 64'(obs_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      if (k < obs_q.size()) check($sformatf("%s.launch%0d", tag, k), 64'(obs_q[k]), 64'(exp_q[k]));
    check($sformatf("%s.done", tag), 64'(bus.DONE), 64'(!exp_err));
    check($sformatf("%s.err", tag), 64'(bus.ERR), 64'(exp_err));
    if (exp_err) check($sformatf("%s.err_idx", tag), 64'(bus.ERR_IDX), 64'(exp_idx));
    check($sformatf("%s.busy_end", tag), 64'(bus.BUSY), 64'd0);
    check($sformatf("%s.w_go_end", tag), 64'(bus.W_GO), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s.w_go", tag), 64'(bus.W_GO), 64'd0);
    check($sformatf("%s.busy", tag), 64'(bus.BUSY), 64'd0);
    check($sformatf("%s.done", tag), 64'(bus.DONE), 64'd0);
    check($sformatf("%s.err", tag), 64'(bus.ERR), 64'd0);
    check($sformatf("%s.err_idx", tag), 64'(bus.ERR_IDX), 64'd0);
    check($sformatf("%s.tbl_addr", tag), 64'(bus.TBL_ADDR), 64'd0);
    check($sformatf("%s.w_data", tag),
          64'({bus.W_SLAVE_ADDRESS, bus.W_BYTE_NUM, bus.W_REG_DATA}), 64'd0);
  endtask

  initial begin
    int c;
    int n;
    bus.START = 1'b0;
    clear_tbl();

    // power-on reset and writer park
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (8) tick();
    check("park.w_go", 64'(bus.W_GO), 64'd1);
    check("park.busy", 64'(bus.BUSY), 64'd0);

    // single write then terminator
    clear_tbl();
    tbl[0] = {8'h34, 8'd2, 16'h1E00};
    run_seq("t1", 1'b0);
    check("t1.slave", 64'(obs_q.size() > 0 ? obs_q[0][31:24] : 8'h00), 64'h34);

    // middle entry NACKs twice: ERR at idx 1 without retry, three launches with retry
    clear_tbl();
    tbl[0] = {8'h34, 8'd1, 16'h0102};
    tbl[1] = {8'h35, 8'd2, 16'hABCD};
    tbl[2] = {8'h36, 8'd1, 16'h5555};
    nack_plan[8'h35] = 2;
    run_seq("t2t3", 1'b0);

    // delay entries: N units must add exactly N*DELAY_UNIT cycles over a zero delay
    clear_tbl();
    tbl[0] = {8'h34, 8'd1, 16'h0011};
    tbl[1] = {8'hFE, 8'd0, 16'd0};
    tbl[2] = {8'hFE, 8'd0, 16'd3};
    tbl[3] = {8'h36, 8'd1, 16'h0022};
    run_seq("t4", 1'b0);
    check("t4.delay_cycles", 64'(dwell[2] - dwell[1]), 64'(3 * DU));

    // no terminator: last index ends clean
    for (int i = 0; i < N_ENT; i++) tbl[i] = {8'hFE, 8'd0, 16'd0};
    tbl[0]         = {8'h41, 8'd2, 16'h1234};
    tbl[N_ENT - 1] = {8'h42, 8'd1, 16'hBEEF};
    run_seq("wrap", 1'b0);

    // START while busy is ignored
    clear_tbl();
    for (int i = 0; i < 6; i++) tbl[i] = {8'(8'h60 + i), 8'(i), 16'($urandom)};
    run_seq("restart_mid", 1'b1);

    // writer never starts: ERR after one LAUNCH cycle, TIMEOUT waiting cycles and the ERR-state cycle
    clear_tbl();
    tbl[0] = {8'h34, 8'd1, 16'h0001};
    tbl[1] = {8'h35, 8'd1, 16'h0002};
    hang_lo = 1'b1;
    obs_q.delete();
    pulse_start();
    c = 0;
    while (!bus.ERR && c < int'(TO) + 40) begin
      tick();
      c++;
    end
    check("t5.err", 64'(bus.ERR), 64'd1);
    check("t5.elapsed", 64'(cyc - launch_cyc), 64'(TO + 2));
    check("t5.err_idx", 64'(bus.ERR_IDX), 64'd0);
    repeat (4) tick();
    check("t5.n_launch", 64'(obs_q.size()), 64'd1);
    check("t5.w_go", 64'(bus.W_GO), 64'd1);
    hang_lo = 1'b0;

    // writer never finishes: ERR from the END_OK-high wait
    hang_hi = 1'b1;
    tbl[0] = {8'h51, 8'd1, 16'h0003};
    tbl[1] = {8'h52, 8'd1, 16'h0004};
    tbl[2] = {8'hFF, 24'd0};
    pulse_start();
    c = 0;
    while (!bus.ERR && c < 3 * int'(TO)) begin
      tick();
      c++;
    end
    check("t5b.err", 64'(bus.ERR), 64'd1);
    check("t5b.err_idx", 64'(bus.ERR_IDX), 64'd0);
    check("t5b.done", 64'(bus.DONE), 64'd0);
    hang_hi = 1'b0;
    repeat (30) tick();

    // reset during a long transfer, then a fresh run from index 0
    len_min = 40;
    len_max = 40;
    obs_q.delete();
    pulse_start();
    c = 0;
    while (obs_q.size() == 0 && c < 100) begin
      tick();
      c++;
    end
    check("t6.launched", 64'(obs_q.size()), 64'd1);
    repeat (6) tick();
    check("t6.busy_before", 64'(bus.BUSY), 64'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("t6");
    repeat (2) tick();
    rst = 1'b0;
    len_min = 1;
    len_max = 12;
    repeat (8) tick();
    run_seq("t6_rerun", 1'b0);

    // random tables with random NACK plans
    for (int r = 0; r < 12; r++) begin
      clear_tbl();
      n = $urandom_range(N_ENT, 1);
      for (int i = 0; i < N_ENT; i++) begin
        if (i < n) begin
          if ($urandom_range(4, 0) == 0) tbl[i] = {8'hFE, 8'($urandom), 16'($urandom_range(3, 0))};
          else begin
            tbl[i] = {8'(8'h10 + i), 8'($urandom), 16'($urandom)};
            if ($urandom_range(5, 0) == 0) nack_plan[8'h10 + i] = $urandom_range(MR + 1, 1);
          end
        end else if (i == n) tbl[i] = {8'hFF, 24'($urandom)};
        else tbl[i] = {8'(8'h50 + i), 8'($urandom), 16'($urandom)};
      end
      run_seq($sformatf("rand%0d", r), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
